mor1kx_ctrl_spr_access_cappuccino: RTL

//  Ctrl-stage responder for l.mfspr/l.mtspr; produces the ack/data that release ctrl stall.

---
 rtl/mor1kx_ctrl_spr_access_cappuccino_if.sv | 27 ++
 rtl/mor1kx_ctrl_spr_access_cappuccino.sv | 118 +++++++++++
 2 files changed

// File: rtl/mor1kx_ctrl_spr_access_cappuccino_if.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_ctrl_spr_access_cappuccino_if
// Brief    : SPR bus bundle between the ctrl-stage SPR responder and SPR slaves.
// Revision : 1.0 - initial release
// ============================================================================
interface mor1kx_ctrl_spr_access_cappuccino_if #(
    parameter int W = 32
);
    logic [15:0]  addr;
    logic         we;
    logic         stb;
    logic [W-1:0] dat_w;
    logic [W-1:0] dat_r;
    logic         ack;

    modport master (
        output addr, we, stb, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  addr, we, stb, dat_w,
        output dat_r, ack
    );
endinterface
`default_nettype wire

// File: rtl/mor1kx_ctrl_spr_access_cappuccino.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_ctrl_spr_access_cappuccino
// Brief    : Ctrl-stage l.mfspr/l.mtspr responder; one SPR bus access per op.
//            Optional access timeout enabled by MOR1KX_SPR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_ctrl_spr_access_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_SPR_TIMEOUT   = 16
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic                            ctrl_op_mfspr_i,
    input  wire logic                            ctrl_op_mtspr_i,
    input  wire logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  wire logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
    input  wire logic                            pipeline_flush_i,
    mor1kx_ctrl_spr_access_cappuccino_if.master  spr_bus,
    output logic                                 ctrl_mfspr_ack_o,
    output logic                                 ctrl_mtspr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]      mfspr_dat_o,
    output logic                                 spr_timeout_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    logic [1:0]                      state;
    logic [15:0]                     bus_addr;
    logic                            bus_we;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_dat;
    logic [OPTION_OPERAND_WIDTH-1:0] read_dat;
    logic                            timed_out;
    logic                            timeout_hit;

    // Only the low 16 address bits select an SPR.
    logic unused_alu_hi;
    assign unused_alu_hi = ^ctrl_alu_result_i[OPTION_OPERAND_WIDTH-1:16];

`ifdef MOR1KX_SPR_TIMEOUT_EN
    localparam int CNT_W = (OPTION_SPR_TIMEOUT > 2) ? $clog2(OPTION_SPR_TIMEOUT) : 1;
    logic [CNT_W-1:0] timeout_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            timeout_cnt <= '0;
        else if (state != ACCESS)
            timeout_cnt <= '0;
        else
            timeout_cnt <= timeout_cnt + 1'b1;
    end

    assign timeout_hit = (timeout_cnt == CNT_W'(OPTION_SPR_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_dat   <= '0;
            read_dat  <= '0;
            timed_out <= 1'b0;
        end else begin
            timed_out <= 1'b0;
            case (state)
                IDLE: begin
                    if ((ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~pipeline_flush_i) begin
                        state    <= ACCESS;
                        bus_addr <= ctrl_alu_result_i[15:0];
                        bus_dat  <= ctrl_rfb_i;
                        bus_we   <= ctrl_op_mtspr_i;
                    end
                end
                ACCESS: begin
                    // Flush beats a same-cycle bus ack: the op is being discarded.
                    if (pipeline_flush_i) begin
                        state <= IDLE;
                    end else if (spr_bus.ack) begin
                        state <= ACK;
                        if (!bus_we)
                            read_dat <= spr_bus.dat_r;
                    end else if (timeout_hit) begin
                        state     <= ACK;
                        timed_out <= 1'b1;
                        if (!bus_we)
                            read_dat <= '0;
                    end
                end
                // ACK always returns to IDLE so a still-held op cannot reissue.
                default: state <= IDLE;
            endcase
        end
    end

    assign spr_bus.addr  = bus_addr;
    assign spr_bus.we    = bus_we;
    assign spr_bus.dat_w = bus_dat;
    assign spr_bus.stb   = (state == ACCESS);

    assign ctrl_mfspr_ack_o = (state == ACK) & ~bus_we;
    assign ctrl_mtspr_ack_o = (state == ACK) &  bus_we;
    assign mfspr_dat_o      = read_dat;

`ifdef MOR1KX_SPR_TIMEOUT_EN
    assign spr_timeout_o = timed_out;
`else
    assign spr_timeout_o = 1'b0;
    logic unused_timed_out;
    assign unused_timed_out = timed_out;
`endif

endmodule
`default_nettype wire
